// File: rtl/mips_mem_arbiter.sv
// Shares one single-port memory between the IF fetch port and the MEM-stage data port.
// One access in flight at a time; D has priority, and a starvation guard lets IF through.
module mips_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [2:0] LAT = 3'(MEM_LAT);

  logic [1:0]    state;
  logic [2:0]    lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          flush_flg;
  logic          sel_d;
  logic          we_q;
  logic          win_if;

  // IF wins when alone, or when it has lost STARVE_MAX times in a row
  assign win_if = if_req && (!d_req || starve_cnt == SMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      flush_flg  <= 1'b0;
      sel_d      <= 1'b0;
      we_q       <= 1'b0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      d_gnt      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            sel_d  <= !win_if;
            we_q   <= !win_if && d_we;
            if_gnt <= win_if;
            d_gnt  <= !win_if;
            mem_en <= 1'b1;
            mem_we <= !win_if && d_we;
            if (win_if) begin
              mem_addr   <= if_addr;
              starve_cnt <= '0;
            end else begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (if_req && starve_cnt != SMAX)
                starve_cnt <= starve_cnt + SW'(1);
            end
          end
        end
        ISSUE: begin
          if (!sel_d && if_flush)
            flush_flg <= 1'b1;
          if (we_q) begin
            state    <= RESP;
            d_rvalid <= 1'b1;
          end else begin
            state   <= WAIT;
            lat_cnt <= 3'd1;
          end
        end
        WAIT: begin
          if (!sel_d && if_flush)
            flush_flg <= 1'b1;
          if (lat_cnt == LAT) begin
            state <= RESP;
            if (sel_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_rdata;
            end else if (!(flush_flg || if_flush)) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          flush_flg <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: vector table plus hand sequences
// for arbitration, starvation, flush and mid-access reset.
module tb_mips_mem_arbiter;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, rst3_n;
  always #5 clk = ~clk;

  logic        if_req, if_flush, d_req, d_we;
  logic [9:0]  if_addr, d_addr;
  logic [31:0] d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic        mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  logic        t3_if_req;
  logic [9:0]  t3_if_addr;
  logic        z_bit;
  logic [9:0]  z_addr;
  logic [31:0] z_data;
  logic        t3_if_gnt, t3_if_rvalid, t3_d_gnt, t3_d_rvalid;
  logic        t3_mem_en, t3_mem_we, t3_busy;
  logic [31:0] t3_if_rdata, t3_d_rdata, t3_mem_wdata, t3_mem_rdata;
  logic [9:0]  t3_mem_addr;

  mips_mem_arbiter #(.MEM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mips_mem_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .if_req(t3_if_req), .if_addr(t3_if_addr), .if_flush(z_bit),
    .if_gnt(t3_if_gnt), .if_rvalid(t3_if_rvalid), .if_rdata(t3_if_rdata),
    .d_req(z_bit), .d_we(z_bit), .d_addr(z_addr), .d_wdata(z_data),
    .d_gnt(t3_d_gnt), .d_rvalid(t3_d_rvalid), .d_rdata(t3_d_rdata),
    .mem_en(t3_mem_en), .mem_we(t3_mem_we), .mem_addr(t3_mem_addr),
    .mem_wdata(t3_mem_wdata), .mem_rdata(t3_mem_rdata), .busy(t3_busy)
  );

  // memory model: data valid MEM_LAT cycles after mem_en, junk otherwise
  logic [31:0] mem [1024];
  logic [31:0] s0, s1, s2;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_en ? mem[mem_addr] : 32'hdeadbeef;
    s0 <= t3_mem_en ? mem[t3_mem_addr] : 32'hdeadbeef;
    s1 <= s0;
    s2 <= s1;
  end
  assign t3_mem_rdata = s2;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_d, last_if;
  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit d, bit w, logic [9:0] a,
                              logic [31:0] wd, logic [31:0] e);
    vec_t v;
    v.is_d = d; v.we = w; v.addr = a; v.wdata = wd; v.exp = e;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    tick();
    chk("gnt", {if_gnt, d_gnt}, v.is_d ? 2'b01 : 2'b10);
    chk("mem_en", mem_en, 1);
    chk("mem_we", mem_we, v.is_d & v.we);
    chk("mem_addr", mem_addr, v.addr);
    chk("busy", busy, 1);
    if (v.is_d && v.we) chk("mem_wdata", mem_wdata, v.wdata);
    d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
    tick();
    chk("mem_en_off", mem_en, 0);
    chk("addr_hold", mem_addr, v.addr);
    if (v.is_d && v.we) begin
      chk("wr_ack", {if_rvalid, d_rvalid}, 2'b01);
      chk("d_rdata_keep", d_rdata, last_d);
    end else begin
      chk("rv_early", {if_rvalid, d_rvalid}, 2'b00);
      tick();
      chk("rvalid", {if_rvalid, d_rvalid}, v.is_d ? 2'b01 : 2'b10);
      chk("rdata", v.is_d ? d_rdata : if_rdata, v.exp);
      if (v.is_d) last_d = v.exp;
      else last_if = v.exp;
    end
    tick();
    chk("idle", {busy, if_rvalid, d_rvalid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ng;
    logic dseq [10];
    logic [9:0] pat;
    vecs[0]  = mk(1, 1, 10'd5,    32'h14431000, 32'h0);
    vecs[1]  = mk(1, 1, 10'd200,  32'h3,        32'h0);
    vecs[2]  = mk(1, 1, 10'd1023, 32'ha5a5a5a5, 32'h0);
    vecs[3]  = mk(1, 1, 10'd0,    32'hffffffff, 32'h0);
    vecs[4]  = mk(0, 0, 10'd5,    32'h0,        32'h14431000);
    vecs[5]  = mk(1, 0, 10'd200,  32'h0,        32'h3);
    vecs[6]  = mk(1, 1, 10'd198,  32'h6,        32'h0);
    vecs[7]  = mk(1, 0, 10'd198,  32'h0,        32'h6);
    vecs[8]  = mk(0, 0, 10'd1023, 32'h0,        32'ha5a5a5a5);
    vecs[9]  = mk(1, 0, 10'd0,    32'h0,        32'hffffffff);
    vecs[10] = mk(0, 0, 10'd0,    32'h0,        32'hffffffff);
    vecs[11] = mk(1, 1, 10'd0,    32'h12345678, 32'h0);
    vecs[12] = mk(0, 0, 10'd0,    32'h0,        32'h12345678);

    if_req = 0; if_flush = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    t3_if_req = 0; t3_if_addr = 0;
    z_bit = 0; z_addr = 0; z_data = 0;
    rst_n = 0; rst3_n = 0;
    last_d = 0; last_if = 0;
    tick(); tick();
    chk("rst_ctl", {if_gnt, if_rvalid, d_gnt, d_rvalid,
                    mem_en, mem_we, busy}, 0);
    chk("rst_data", if_rdata | d_rdata | mem_wdata, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1; rst3_n = 1;
    tick();
    chk("idle_no_req", busy, 0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // both request at once: D first, IF in the next IDLE slot
    d_req = 1; d_we = 0; d_addr = 10'd200;
    if_req = 1; if_addr = 10'd5;
    tick();
    chk("t2_gnt", {if_gnt, d_gnt}, 2'b01);
    d_req = 0;
    tick(); tick();
    chk("t2_d_rv", d_rvalid, 1);
    chk("t2_d_rdata", d_rdata, 3);
    tick();
    chk("t2_idle", {if_gnt, busy}, 0);
    tick();
    chk("t2_if_gnt", if_gnt, 1);
    if_req = 0;
    tick(); tick();
    chk("t2_if_rv", if_rvalid, 1);
    chk("t2_if_rdata", if_rdata, 32'h14431000);
    last_d = 3; last_if = 32'h14431000;
    tick();

    // flush during WAIT
    if_req = 1; if_addr = 10'd200;
    tick();
    chk("t4_gnt", if_gnt, 1);
    if_req = 0;
    tick();
    if_flush = 1;
    tick();
    if_flush = 0;
    chk("t4_rv_supp", if_rvalid, 0);
    chk("t4_rdata_keep", if_rdata, last_if);
    chk("t4_busy_resp", busy, 1);
    tick();
    chk("t4_busy_low", busy, 0);
    // flush during ISSUE only
    if_req = 1; if_addr = 10'd1023;
    tick();
    if_req = 0; if_flush = 1;
    tick();
    if_flush = 0;
    tick();
    chk("t4b_rv_supp", if_rvalid, 0);
    chk("t4b_rdata_keep", if_rdata, last_if);
    tick();
    // flush in IDLE has no effect on the next fetch
    if_flush = 1;
    tick();
    if_flush = 0;
    run_vec(mk(0, 0, 10'd200, 32'h0, 32'h3));
    // flush during a D access is ignored
    if_flush = 1;
    run_vec(mk(1, 0, 10'd1023, 32'h0, 32'ha5a5a5a5));
    if_flush = 0;

    // starvation guard with both requests held
    rst_n = 0;
    tick();
    rst_n = 1;
    last_d = 0; last_if = 0;
    chk("t3_rst_rdata", d_rdata | if_rdata, 0);
    if_req = 1; if_addr = 10'd5;
    d_req = 1; d_we = 0; d_addr = 10'd200;
    ng = 0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      tick();
      if (d_gnt || if_gnt) begin
        dseq[ng] = d_gnt;
        ng++;
      end
    end
    if_req = 0; d_req = 0;
    chk("t3_grants", ng, 10);
    pat = 10'b1111011110;
    for (int i = 0; i < 10; i++)
      if (i < ng) chk($sformatf("t3_seq%0d", i), dseq[i], pat[9-i]);
    for (int c = 0; c < 6; c++) tick();
    chk("t3_drain", busy, 0);

    // MEM_LAT=3 instance: reset mid-WAIT drops the access
    t3_if_req = 1; t3_if_addr = 10'd5;
    tick();
    chk("t6_gnt", {t3_if_gnt, t3_mem_en}, 2'b11);
    t3_if_req = 0;
    tick();
    chk("t6_busy", t3_busy, 1);
    #3 rst3_n = 0;
    #1;
    chk("t6_rst_ctl", {t3_if_gnt, t3_if_rvalid, t3_d_gnt, t3_d_rvalid,
                       t3_mem_en, t3_mem_we, t3_busy}, 0);
    chk("t6_rst_addr", t3_mem_addr, 0);
    tick();
    #3 rst3_n = 1;
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (t3_if_rvalid || t3_busy) ng++;
    end
    chk("t6_no_resp", ng, 0);
    // normal LAT=3 fetch afterwards: rvalid at T+5
    t3_if_req = 1; t3_if_addr = 10'd1023;
    tick();
    chk("t6b_gnt", t3_if_gnt, 1);
    t3_if_req = 0;
    ng = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (t3_if_rvalid) ng++;
    end
    chk("t6b_rv_early", ng, 0);
    tick();
    chk("t6b_rv", t3_if_rvalid, 1);
    chk("t6b_rdata", t3_if_rdata, 32'ha5a5a5a5);
    tick();
    chk("t6b_idle", t3_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
